// File: rtl/merge2_rr_pkg.sv
// Shared constants and helpers for the two-input round-robin merge stage.
package merge2_rr_pkg;

  localparam int unsigned CGRA_DATA_SIZE = 8;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/merge2_rr_if.sv
// Handshake bundle for merge2_rr: two upstream channels, the one-hot selects
// and the downstream FIFO head.
interface merge2_rr_if
  import merge2_rr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = CGRA_DATA_SIZE
);

  logic [DATA_SIZE-1:0] in0_data;
  logic                 in0_valid;
  logic                 in0_ready;
  logic [DATA_SIZE-1:0] in1_data;
  logic                 in1_valid;
  logic                 in1_ready;
  logic                 sel0;
  logic                 sel1;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, sel0, sel1, out_data, out_valid
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, sel0, sel1, out_data, out_valid
  );

endinterface

// File: rtl/merge2_fifo.sv
// DEPTH-entry synchronous FIFO; push is ignored when full, pop when empty.
module merge2_fifo
  import merge2_rr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = CGRA_DATA_SIZE,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_SIZE-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !reset_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/select2.sv
// One-hot two-way data select; simulation halts if both selects are ever high.
module select2
  import merge2_rr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = CGRA_DATA_SIZE
) (
  input  logic                 sel0,
  input  logic                 sel1,
  input  logic [DATA_SIZE-1:0] in0_data,
  input  logic [DATA_SIZE-1:0] in1_data,
  output logic [DATA_SIZE-1:0] out_data
);

  always_comb begin
    out_data = ({DATA_SIZE{sel0}} & in0_data) | ({DATA_SIZE{sel1}} & in1_data);
    assert (!(sel0 && sel1)) else $fatal(1, "select2: sel0 and sel1 both high");
  end

endmodule

// File: rtl/merge2_rr.sv
// Two-input round-robin merge: grants one channel per cycle into a small FIFO
// and exposes the one-hot grant pair that drives the downstream select2.
module merge2_rr
  import merge2_rr_pkg::*;
#(
  parameter int unsigned DATA_SIZE = CGRA_DATA_SIZE,
  parameter int unsigned DEPTH     = 2
) (
  input  logic           clk,
  input  logic           reset,
  merge2_rr_if.slave     bus
);

  logic                 prio_q, prio_d;
  logic                 full, empty;
  logic                 sel0, sel1, grant, pop;
  logic [DATA_SIZE-1:0] mux_data;

  // Grant ignores out_ready: a full FIFO blocks pushes even if it pops this cycle.
  always_comb begin
    sel0 = !reset && !full && bus.in0_valid && (!prio_q || !bus.in1_valid);
    sel1 = !reset && !full && bus.in1_valid && ( prio_q || !bus.in0_valid);
  end

  assign grant = sel0 || sel1;
  assign pop   = !empty && bus.out_ready;

  always_comb begin
    prio_d = prio_q;
    if (grant) prio_d = sel0;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  select2 #(.DATA_SIZE(DATA_SIZE)) u_select2 (
    .sel0     (sel0),
    .sel1     (sel1),
    .in0_data (bus.in0_data),
    .in1_data (bus.in1_data),
    .out_data (mux_data)
  );

  merge2_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (grant),
    .wdata_i (mux_data),
    .pop_i   (pop),
    .rdata_o (bus.out_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.sel0      = sel0;
  assign bus.sel1      = sel1;
  assign bus.in0_ready = sel0;
  assign bus.in1_ready = sel1;
  assign bus.out_valid = !empty;

endmodule

// File: tb/tb_merge2_rr.sv
// Directed bench for merge2_rr: inputs change on the falling edge, checks follow 1ns later.
module tb_merge2_rr;

  logic clk = 1'b0;
  logic reset;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  merge2_rr_if #(.DATA_SIZE(8)) bus ();

  merge2_rr #(.DATA_SIZE(8), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic ordy);
    @(negedge clk);
    reset         = r;
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
    #1;
  endtask

  initial begin
    int unsigned w;
    reset         = 1'b1;
    bus.in0_valid = 1'b1;
    bus.in0_data  = 8'h11;
    bus.in1_valid = 1'b1;
    bus.in1_data  = 8'h22;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset with both channels valid
    drive(1, 1, 8'h11, 1, 8'h22, 1);
    chk("rst_in0_ready", bus.in0_ready, 0);
    chk("rst_in1_ready", bus.in1_ready, 0);
    chk("rst_sel0", bus.sel0, 0);
    chk("rst_sel1", bus.sel1, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("first_grant_sel0", bus.sel0, 1);
    chk("first_grant_sel1", bus.sel1, 0);
    chk("first_grant_in0_ready", bus.in0_ready, 1);
    chk("first_out_valid", bus.out_valid, 0);
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("after_rst_out_valid", bus.out_valid, 1);
    chk("after_rst_out_data_11", bus.out_data, 32'h11);
    chk("second_grant_sel1", bus.sel1, 1);
    chk("second_grant_sel0", bus.sel0, 0);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("after_rst_out_data_22", bus.out_data, 32'h22);
    chk("idle_sel0", bus.sel0, 0);
    chk("idle_sel1", bus.sel1, 0);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("drained_out_valid", bus.out_valid, 0);

    // Both channels always valid, draining: strict alternation
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 8'((k + 1) / 2), 1, 8'(8'h80 + k / 2), 1);
      chk("alt_sel0", bus.sel0, 32'(k % 2 == 0));
      chk("alt_sel1", bus.sel1, 32'(k % 2 == 1));
      if (k > 0) begin
        w = ((k - 1) % 2 == 0) ? (k - 1) / 2 : 32'h80 + (k - 1) / 2;
        chk("alt_out_valid", bus.out_valid, 1);
        chk("alt_out_data", bus.out_data, w);
      end
    end
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("alt_last_out_data", bus.out_data, 32'h83);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("alt_drained", bus.out_valid, 0);

    // Only channel 1 valid while channel 0 preferred
    drive(0, 0, 8'h00, 1, 8'h5A, 1);
    chk("solo1_sel1", bus.sel1, 1);
    chk("solo1_sel0", bus.sel0, 0);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("solo1_out_data", bus.out_data, 32'h5A);

    // Backpressure with DEPTH=2
    drive(0, 1, 8'h10, 1, 8'h20, 0);
    chk("prio_back_to_0", bus.sel0, 1);
    drive(0, 1, 8'h11, 1, 8'h20, 0);
    chk("bp_second_sel1", bus.sel1, 1);
    chk("bp_head_10", bus.out_data, 32'h10);
    drive(0, 1, 8'h11, 1, 8'h21, 0);
    chk("bp_full_in0_ready", bus.in0_ready, 0);
    chk("bp_full_in1_ready", bus.in1_ready, 0);
    drive(0, 1, 8'h11, 1, 8'h21, 0);
    chk("bp_hold_in0_ready", bus.in0_ready, 0);
    chk("bp_hold_in1_ready", bus.in1_ready, 0);
    drive(0, 1, 8'h11, 1, 8'h21, 1);
    chk("bp_nobypass_in0_ready", bus.in0_ready, 0);
    chk("bp_nobypass_in1_ready", bus.in1_ready, 0);
    chk("bp_pop_10", bus.out_data, 32'h10);
    drive(0, 1, 8'h11, 1, 8'h21, 1);
    chk("bp_resume_sel0", bus.sel0, 1);
    chk("bp_pop_20", bus.out_data, 32'h20);
    drive(0, 0, 8'h00, 1, 8'h21, 1);
    chk("bp_resume_sel1", bus.sel1, 1);
    chk("bp_pop_11", bus.out_data, 32'h11);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("bp_pop_21", bus.out_data, 32'h21);

    // Simultaneous push and pop at count=1
    drive(0, 1, 8'h33, 0, 8'h00, 1);
    chk("pp_push33_sel0", bus.sel0, 1);
    chk("pp_empty_before", bus.out_valid, 0);
    drive(0, 0, 8'h00, 1, 8'h44, 1);
    chk("pp_push44_sel1", bus.sel1, 1);
    chk("pp_head_33", bus.out_data, 32'h33);
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    chk("pp_valid_after", bus.out_valid, 1);
    chk("pp_head_44", bus.out_data, 32'h44);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("pp_head_44_hold", bus.out_data, 32'h44);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("pp_count_was_1", bus.out_valid, 0);

    // Reset with two buffered words
    drive(0, 1, 8'h55, 1, 8'h66, 0);
    chk("rf_sel0", bus.sel0, 1);
    drive(0, 1, 8'h56, 1, 8'h66, 0);
    chk("rf_sel1", bus.sel1, 1);
    drive(1, 1, 8'h56, 1, 8'h67, 0);
    chk("rf_rst_sel0", bus.sel0, 0);
    chk("rf_rst_sel1", bus.sel1, 0);
    chk("rf_rst_in0_ready", bus.in0_ready, 0);
    chk("rf_rst_in1_ready", bus.in1_ready, 0);
    chk("rf_full_before_rst", bus.out_valid, 1);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("rf_out_valid_cleared", bus.out_valid, 0);
    drive(0, 0, 8'h00, 1, 8'h99, 1);
    chk("rf_no_stale", bus.out_valid, 0);
    chk("rf_new_sel1", bus.sel1, 1);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("rf_new_word", bus.out_data, 32'h99);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("rf_final_empty", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
